// File: rtl/instruction_loader_if.sv
// instruction_loader_if: loader bus; host (master) drives start/base_addr/in_*, loader (slave) drives in_ready, memory write port and status
interface instruction_loader_if #(parameter int MEM_ADDR_WIDTH = 9);
  logic start;
  logic [MEM_ADDR_WIDTH-1:0] base_addr;
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic in_ready;
  logic mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic busy;
  logic done;
  logic [1:0] err_code;
  logic [MEM_ADDR_WIDTH:0] instr_count;
  modport master (
    output start, base_addr, in_valid, in_data, in_last,
    input in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_code, instr_count
  );
  modport slave (
    input start, base_addr, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_code, instr_count
  );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: packs host byte pairs {itype,data} into 16-bit instruction-memory writes; ports clk, rst (async high), bus (slave: start/base_addr/in_* in, in_ready/mem_*/busy/done/err_code/instr_count out)
module instruction_loader #(
  parameter int MEM_ADDR_WIDTH = 9
) (
  input logic clk,
  input logic rst,
  instruction_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GET_TYPE, GET_DATA, WRITE, DRAIN, FINISH} state_t;
  localparam logic [MEM_ADDR_WIDTH:0] CAP = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};
  state_t state, state_n;
  logic [MEM_ADDR_WIDTH-1:0] addr, addr_n;
  logic [MEM_ADDR_WIDTH:0] count, count_n;
  logic [7:0] itype, itype_n, data, data_n;
  logic last, last_n;
  logic [1:0] err, err_n, code;
  logic xfer;
  assign xfer = bus.in_valid && bus.in_ready;
  // error a type byte would raise: full memory outranks a bad opcode, which outranks a trailing odd byte
  assign code = (count == CAP) ? 2'd3 : (bus.in_data > 8'd6) ? 2'd1 : bus.in_last ? 2'd2 : 2'd0;
  always_comb begin
    state_n = state;
    addr_n = addr;
    count_n = count;
    itype_n = itype;
    data_n = data;
    last_n = last;
    err_n = err;
    case (state)
      IDLE: if (bus.start) begin
        state_n = GET_TYPE;
        addr_n = bus.base_addr;
        count_n = '0;
        err_n = 2'd0;
      end
      GET_TYPE: if (xfer) begin
        itype_n = (code == 2'd0) ? bus.in_data : itype;
        err_n = (code != 2'd0 && err == 2'd0) ? code : err;
        state_n = (code == 2'd0) ? GET_DATA : bus.in_last ? FINISH : DRAIN;
      end
      GET_DATA: if (xfer) begin
        data_n = bus.in_data;
        last_n = bus.in_last;
        state_n = WRITE;
      end
      WRITE: begin
        addr_n = addr + 1'b1;
        count_n = count + 1'b1;
        state_n = last ? FINISH : GET_TYPE;
      end
      DRAIN: state_n = (xfer && bus.in_last) ? FINISH : DRAIN;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      count <= '0;
      itype <= '0;
      data <= '0;
      last <= 1'b0;
      err <= 2'd0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      count <= count_n;
      itype <= itype_n;
      data <= data_n;
      last <= last_n;
      err <= err_n;
    end
  assign bus.in_ready = state inside {GET_TYPE, GET_DATA, DRAIN};
  assign bus.mem_we = state == WRITE;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = {itype, data};
  assign bus.busy = state != IDLE;
  assign bus.done = state == FINISH;
  assign bus.err_code = err;
  assign bus.instr_count = count;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized and directed loads on 9-bit and 2-bit address instances checked against a stream-level model
module tb_instruction_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [8:0] base_addr = '0;
  logic [7:0] in_data = '0;
  instruction_loader_if #(.MEM_ADDR_WIDTH(9)) b9();
  instruction_loader_if #(.MEM_ADDR_WIDTH(2)) b2();
  instruction_loader #(.MEM_ADDR_WIDTH(9)) dut9 (.clk(clk), .rst(rst), .bus(b9.slave));
  instruction_loader #(.MEM_ADDR_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign b9.start = start & ~sel;
  assign b2.start = start & sel;
  assign b9.base_addr = base_addr;
  assign b2.base_addr = base_addr[1:0];
  assign b9.in_valid = in_valid & ~sel;
  assign b2.in_valid = in_valid & sel;
  assign b9.in_data = in_data;
  assign b2.in_data = in_data;
  assign b9.in_last = in_last;
  assign b2.in_last = in_last;
  logic rdy, we, busy, done;
  logic [8:0] maddr;
  logic [15:0] wdata;
  logic [1:0] err;
  logic [9:0] cnt;
  assign rdy = sel ? b2.in_ready : b9.in_ready;
  assign we = sel ? b2.mem_we : b9.mem_we;
  assign busy = sel ? b2.busy : b9.busy;
  assign done = sel ? b2.done : b9.done;
  assign maddr = sel ? {7'd0, b2.mem_addr} : b9.mem_addr;
  assign wdata = sel ? b2.mem_wdata : b9.mem_wdata;
  assign err = sel ? b2.err_code : b9.err_code;
  assign cnt = sel ? {7'd0, b2.instr_count} : b9.instr_count;
  int cyc = 0;
  int dn = 0;
  int n_chk = 0;
  int n_pass = 0;
  int first_data_cyc = 0;
  int exp_err, exp_cnt;
  logic [31:0] wq[$];
  int wcyc[$];
  logic [31:0] exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (we) begin
        wq.push_back({7'd0, maddr, wdata});
        wcyc.push_back(cyc);
      end
      if (done) dn <= dn + 1;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // stream-level reference: walk byte pairs, stop at the first error, remaining bytes are drained
  task automatic model(input logic [7:0] b[$], input int base, input int w);
    int cap = 1 << w;
    exp_q.delete();
    exp_err = 0;
    exp_cnt = 0;
    for (int i = 0; i < b.size(); i += 2) begin
      if (exp_cnt == cap) begin exp_err = 3; break; end
      if (b[i] > 6) begin exp_err = 1; break; end
      if (i == b.size() - 1) begin exp_err = 2; break; end
      exp_q.push_back(32'(((base + exp_cnt) % cap) << 16) | 32'({b[i], b[i+1]}));
      exp_cnt++;
    end
  endtask
  // called on a negedge with the selected loader idle; returns on a negedge with in_valid low
  task automatic drive(input logic [7:0] b[$], input int base, input int stall, input bit poke, input bit mark_last);
    start = 1'b1;
    base_addr = 9'(base);
    for (int k = 0; k < b.size(); k++) begin
      int t = 0;
      bit x;
      do begin
        @(negedge clk);
        start = poke && ($urandom_range(3) == 0);
        if (poke) base_addr = 9'($urandom);
        in_valid = $urandom_range(99) >= stall;
        in_data = b[k];
        in_last = mark_last && (k == b.size() - 1);
        x = in_valid && rdy;
        if (x && k == 1) first_data_cyc = cyc;
        t++;
      end while (!x && t < 200);
      check("xfer_timeout", 32'(x), 32'd1);
      if (!x) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [7:0] b[$], input int base, input int stall, input bit poke);
    int w0 = wq.size();
    int d0 = dn;
    int k;
    model(b, base, sel ? 2 : 9);
    drive(b, base, stall, poke, 1'b1);
    for (k = 0; k < 60 && busy; k++) @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_nwr"}, 32'(wq.size() - w0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) check({tag, "_wr"}, wq[w0+i], exp_q[i]);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    check({tag, "_done"}, 32'(dn - d0), 32'd1);
    if (exp_q.size() > 0 && wq.size() > w0) check({tag, "_lat"}, 32'(wcyc[w0]), 32'(first_data_cyc + 1));
    if (stall == 0)
      for (int i = 1; i < exp_q.size() && w0 + i < wq.size(); i++) check({tag, "_tput"}, 32'(wcyc[w0+i] - wcyc[w0+i-1]), 32'd3);
  endtask
  initial begin
    logic [7:0] q[$];
    int w0, d0, n;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(maddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    q = '{8'h02, 8'h61, 8'h03, 8'h00, 8'h00, 8'h00};
    w0 = wq.size();
    run("basic", q, 'h10, 0, 1'b0);
    if (wq.size() >= w0 + 3) begin
      check("basic_w0", wq[w0], 32'h0010_0261);
      check("basic_w1", wq[w0+1], 32'h0011_0300);
      check("basic_w2", wq[w0+2], 32'h0012_0000);
    end
    run("stall", q, 'h10, 50, 1'b1);
    q = '{8'h02, 8'h61, 8'h09, 8'h05, 8'h01, 8'h02};
    run("badop", q, 'h10, 0, 1'b0);
    q = '{8'h05, 8'h00, 8'h01};
    run("odd", q, 'h40, 0, 1'b0);
    sel = 1'b1;
    q = '{8'h00, 8'h11, 8'h01, 8'h22, 8'h02, 8'h33, 8'h03, 8'h44, 8'h04, 8'h55};
    w0 = wq.size();
    run("ovf", q, 3, 0, 1'b0);
    if (wq.size() >= w0 + 4) check("ovf_wrap", wq[w0+1], 32'h0000_0122);
    sel = 1'b0;
    q = '{8'h02, 8'h61, 8'h03};
    w0 = wq.size();
    d0 = dn;
    drive(q, 'h10, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(rdy), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(maddr), 32'd0);
    check("mrst_wdata", 32'(wdata), 32'd0);
    check("mrst_cnt", 32'(cnt), 32'd0);
    check("mrst_we", 32'(we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_nwr", 32'(wq.size() - w0), 32'd1);
    check("mrst_done", 32'(dn - d0), 32'd0);
    for (int r = 0; r < 24; r++) begin
      sel = (r % 4 == 3);
      n = $urandom_range(sel ? 7 : 6, 1);
      q.delete();
      for (int j = 0; j < n; j++) begin
        q.push_back(($urandom_range(9) == 0) ? 8'($urandom_range(255, 7)) : 8'($urandom_range(6)));
        q.push_back(8'($urandom));
      end
      if ($urandom_range(7) == 0) void'(q.pop_back());
      run("rnd", q, $urandom_range(511), $urandom_range(1) * 40, 1'($urandom_range(1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
